// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard/sequencing controller.
// Forwarding behaviour is selected by the PIPELINE_FORWARDING_EN macro in pipeline_ctrl.sv.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF   = 5;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    typedef struct packed {
        logic       stall_if;
        logic       stall_id;
        logic       stall_ex;
        logic       stall_mem;
        logic       flush_id;
        logic       flush_ex;
        logic       bubble_wb;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
    } ctrl_out_t;

    // Whole pipeline held, WB fed a bubble: used for memory wait and for the halted core
    localparam ctrl_out_t CTRL_FREEZE = '{
        stall_if:  1'b1,
        stall_id:  1'b1,
        stall_ex:  1'b1,
        stall_mem: 1'b1,
        flush_id:  1'b0,
        flush_ex:  1'b0,
        bubble_wb: 1'b1,
        fwd_a:     FWD_REG,
        fwd_b:     FWD_REG
    };

    // The younger producer (MEM) holds the newer value, so it wins over WB
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// Destination/source register match for one producer stage and one consumer operand.
// x0 is never a real producer, so rd==0 never matches.
module pipeline_ctrl_hazard_cmp
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  wen_i,
    output logic                  hit_o
);

    assign hit_o = wen_i && (rd_i != '0) && (rd_i == rs_i);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward controller and halt-drain sequencer for the 5-stage RV32I core.
// Define PIPELINE_FORWARDING_EN for EX operand forwarding; otherwise RAW hazards stall.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic                  id_hlt_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_reg_write_i,
    input  logic                  ex_mem_to_reg_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic                  ex_redirect_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  stall_ex_o,
    output logic                  stall_mem_o,
    output logic                  flush_id_o,
    output logic                  flush_ex_o,
    output logic                  bubble_wb_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  halted_o
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    state_e           eff_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_out_t        ctl;

    logic hit_ex_rs1, hit_ex_rs2, hit_mem_rs1, hit_mem_rs2;
    logic raw_c;
    logic mem_wait_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    pipeline_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_ex_rs1 (
        .rd_i(ex_rd_i), .rs_i(id_rs1_i), .wen_i(ex_reg_write_i), .hit_o(hit_ex_rs1)
    );
    pipeline_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_ex_rs2 (
        .rd_i(ex_rd_i), .rs_i(id_rs2_i), .wen_i(ex_reg_write_i), .hit_o(hit_ex_rs2)
    );
    pipeline_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem_rs1 (
        .rd_i(mem_rd_i), .rs_i(id_rs1_i), .wen_i(mem_reg_write_i), .hit_o(hit_mem_rs1)
    );
    pipeline_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem_rs2 (
        .rd_i(mem_rd_i), .rs_i(id_rs2_i), .wen_i(mem_reg_write_i), .hit_o(hit_mem_rs2)
    );

`ifdef PIPELINE_FORWARDING_EN
    logic hit_wb_rs1, hit_wb_rs2;

    pipeline_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_wb_rs1 (
        .rd_i(wb_rd_i), .rs_i(id_rs1_i), .wen_i(wb_reg_write_i), .hit_o(hit_wb_rs1)
    );
    pipeline_ctrl_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_wb_rs2 (
        .rd_i(wb_rd_i), .rs_i(id_rs2_i), .wen_i(wb_reg_write_i), .hit_o(hit_wb_rs2)
    );

    // Only a load in EX cannot be forwarded in time
    assign raw_c = ex_mem_to_reg_i &&
                   ((id_use_rs1_i && hit_ex_rs1) || (id_use_rs2_i && hit_ex_rs2));
    assign fwd_a_c = fwd_sel(hit_mem_rs1, hit_wb_rs1);
    assign fwd_b_c = fwd_sel(hit_mem_rs2, hit_wb_rs2);
`else
    logic unused_c;

    // Without bypass paths, wait until the producer has reached WB (regfile written first half)
    assign raw_c = (id_use_rs1_i && (hit_ex_rs1 || hit_mem_rs1)) ||
                   (id_use_rs2_i && (hit_ex_rs2 || hit_mem_rs2));
    assign fwd_a_c  = FWD_REG;
    assign fwd_b_c  = FWD_REG;
    assign unused_c = ^{wb_rd_i, wb_reg_write_i, ex_mem_to_reg_i};
`endif

    assign mem_wait_c = dmem_req_i && !dmem_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // On the release cycle of a memory wait, behave exactly as the state we return to
    always_comb begin
        ctl       = '0;
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        eff_state = state_q;
        if ((state_q == ST_MEM_WAIT) && dmem_ready_i) begin
            eff_state = ret_q;
        end

        case (eff_state)
            ST_RUN, ST_DRAIN: begin
                if (mem_wait_c) begin
                    ctl     = CTRL_FREEZE;
                    state_d = ST_MEM_WAIT;
                    ret_d   = eff_state;
                end else begin
                    ctl.fwd_a = fwd_a_c;
                    ctl.fwd_b = fwd_b_c;
                    if (eff_state == ST_DRAIN) begin
                        ctl.stall_if = 1'b1;
                        ctl.stall_id = 1'b1;
                        ctl.flush_ex = 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_HALTED;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DRAIN;
                            cnt_d   = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_RUN;
                        if (ex_redirect_i) begin
                            ctl.flush_id = 1'b1;
                            ctl.flush_ex = 1'b1;
                        end else if (id_hlt_i) begin
                            ctl.flush_ex = 1'b1;
                            state_d      = ST_DRAIN;
                            cnt_d        = CNT_W'(DRAIN_CYCLES);
                        end else if (raw_c) begin
                            ctl.stall_if = 1'b1;
                            ctl.stall_id = 1'b1;
                            ctl.flush_ex = 1'b1;
                        end
                    end
                end
            end
            ST_MEM_WAIT: begin
                ctl = CTRL_FREEZE;
            end
            ST_HALTED: begin
                ctl = CTRL_FREEZE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign stall_if_o  = ctl.stall_if;
    assign stall_id_o  = ctl.stall_id;
    assign stall_ex_o  = ctl.stall_ex;
    assign stall_mem_o = ctl.stall_mem;
    assign flush_id_o  = ctl.flush_id;
    assign flush_ex_o  = ctl.flush_ex;
    assign bubble_wb_o = ctl.bubble_wb;
    assign fwd_a_o     = ctl.fwd_a;
    assign fwd_b_o     = ctl.fwd_b;
    assign halted_o    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed table, multi-cycle sequences, random vs. model.
// Expectations follow PIPELINE_FORWARDING_EN when it is defined for the build.
module tb_pipeline_ctrl;

    localparam int unsigned RW    = 5;
    localparam int unsigned DRAIN = 3;
`ifdef PIPELINE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [RW-1:0] rs1, rs2;
        logic          use1, use2, hlt;
        logic [RW-1:0] ex_rd;
        logic          ex_we, ex_m2r;
        logic [RW-1:0] mem_rd;
        logic          mem_we;
        logic [RW-1:0] wb_rd;
        logic          wb_we;
        logic          redir, req, ready;
    } in_t;

    typedef struct packed {
        logic       stall_if, stall_id, stall_ex, stall_mem;
        logic       flush_id, flush_ex, bubble_wb;
        logic [1:0] fwd_a, fwd_b;
        logic       halted;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk, rst_n;
    in_t  cur;
    logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, halted;
    logic [1:0] fwd_a, fwd_b;

    int errors = 0;
    int checks = 0;

    // Reference model state: draining counts remaining retire cycles, frozen = waiting on memory
    bit m_halted;
    bit m_frozen;
    int m_left;

    pipeline_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2),
        .id_use_rs1_i(cur.use1), .id_use_rs2_i(cur.use2), .id_hlt_i(cur.hlt),
        .ex_rd_i(cur.ex_rd), .ex_reg_write_i(cur.ex_we), .ex_mem_to_reg_i(cur.ex_m2r),
        .mem_rd_i(cur.mem_rd), .mem_reg_write_i(cur.mem_we),
        .wb_rd_i(cur.wb_rd), .wb_reg_write_i(cur.wb_we),
        .ex_redirect_i(cur.redir), .dmem_req_i(cur.req), .dmem_ready_i(cur.ready),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
        .stall_mem_o(stall_mem), .flush_id_o(flush_id), .flush_ex_o(flush_ex),
        .bubble_wb_o(bubble_wb), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .halted_o(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t o;
        o = '{stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
              bubble_wb, fwd_a, fwd_b, halted};
        return o;
    endfunction

    function automatic bit writes(logic [RW-1:0] rd, logic we, logic [RW-1:0] rs);
        return we && (rd != 0) && (rd == rs);
    endfunction

    function automatic logic [1:0] src_sel(in_t v, logic [RW-1:0] rs);
        if (writes(v.mem_rd, v.mem_we, rs)) return 2'b10;
        if (writes(v.wb_rd, v.wb_we, rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit src_hazard(in_t v, logic [RW-1:0] rs);
        if (FWD) return v.ex_m2r && writes(v.ex_rd, v.ex_we, rs);
        return writes(v.ex_rd, v.ex_we, rs) || writes(v.mem_rd, v.mem_we, rs);
    endfunction

    function automatic bit frozen_now(in_t v);
        return m_frozen ? !v.ready : (v.req && !v.ready);
    endfunction

    function automatic out_t model_out(in_t v);
        out_t o;
        o = '0;
        if (m_halted) begin
            {o.stall_if, o.stall_id, o.stall_ex, o.stall_mem, o.bubble_wb, o.halted} = 6'b111111;
            return o;
        end
        if (frozen_now(v)) begin
            {o.stall_if, o.stall_id, o.stall_ex, o.stall_mem, o.bubble_wb} = 5'b11111;
            return o;
        end
        if (FWD) begin
            o.fwd_a = src_sel(v, v.rs1);
            o.fwd_b = src_sel(v, v.rs2);
        end
        if (m_left > 0) begin
            {o.stall_if, o.stall_id, o.flush_ex} = 3'b111;
        end else if (v.redir) begin
            {o.flush_id, o.flush_ex} = 2'b11;
        end else if (v.hlt) begin
            o.flush_ex = 1'b1;
        end else if ((v.use1 && src_hazard(v, v.rs1)) || (v.use2 && src_hazard(v, v.rs2))) begin
            {o.stall_if, o.stall_id, o.flush_ex} = 3'b111;
        end
        return o;
    endfunction

    function automatic void model_next(in_t v);
        if (m_halted) return;
        if (frozen_now(v)) begin
            m_frozen = 1'b1;
            return;
        end
        m_frozen = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_halted = 1'b1;
        end else if (!v.redir && v.hlt) begin
            m_left = DRAIN;
        end
    endfunction

    function automatic void model_reset();
        m_halted = 1'b0;
        m_frozen = 1'b0;
        m_left   = 0;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called at posedge+1: apply, compare mid-cycle, advance model, move to next posedge+1
    task automatic step(in_t v, string name);
        cur = v;
        #1;
        chk(name, 32'(dut_out()), 32'(model_out(v)));
        model_next(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(in_t v, string name);
        cur   = v;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk(name, 32'(dut_out()), 32'(model_out(v)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic out_t exp_o(bit st, bit fid, bit fex, logic [1:0] fa, logic [1:0] fb);
        out_t o;
        o = '0;
        o.stall_if = st;
        o.stall_id = st;
        o.flush_id = fid;
        o.flush_ex = fex;
        o.fwd_a    = fa;
        o.fwd_b    = fb;
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.rs1    = RW'($urandom_range(0, 3));
        v.rs2    = RW'($urandom_range(0, 3));
        v.use1   = ($urandom_range(0, 3) != 0);
        v.use2   = ($urandom_range(0, 3) != 0);
        v.hlt    = ($urandom_range(0, 15) == 0);
        v.ex_rd  = RW'($urandom_range(0, 3));
        v.ex_we  = 1'($urandom_range(0, 1));
        v.ex_m2r = 1'($urandom_range(0, 1));
        v.mem_rd = RW'($urandom_range(0, 3));
        v.mem_we = 1'($urandom_range(0, 1));
        v.wb_rd  = RW'($urandom_range(0, 3));
        v.wb_we  = 1'($urandom_range(0, 1));
        v.redir  = ($urandom_range(0, 7) == 0);
        v.req    = ($urandom_range(0, 2) == 0);
        v.ready  = 1'($urandom_range(0, 1));
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t e;
        in_t  idle, v;
        int   nfreeze;

        idle  = '0;
        cur   = idle;
        rst_n = 1'b0;
        model_reset();

        e.name = "idle";           e.i = idle;
        e.o = exp_o(0, 0, 0, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "load_use_rs1";   e.i = idle;
        e.i.ex_rd = 5; e.i.ex_we = 1; e.i.ex_m2r = 1;
        e.i.rs1 = 5; e.i.use1 = 1; e.i.rs2 = 1; e.i.use2 = 1;
        e.o = exp_o(1, 0, 1, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "mem_over_wb";    e.i = idle;
        e.i.mem_rd = 3; e.i.mem_we = 1; e.i.wb_rd = 3; e.i.wb_we = 1; e.i.rs1 = 3; e.i.use1 = 1;
        e.o = FWD ? exp_o(0, 0, 0, 2'b10, 2'b00) : exp_o(1, 0, 1, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "wb_only";        e.i = idle;
        e.i.wb_rd = 3; e.i.wb_we = 1; e.i.rs1 = 3; e.i.use1 = 1;
        e.o = exp_o(0, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00); tbl.push_back(e);
        e.name = "x0_masked";      e.i = idle;
        e.i.ex_we = 1; e.i.ex_m2r = 1; e.i.mem_we = 1; e.i.wb_we = 1; e.i.use1 = 1; e.i.use2 = 1;
        e.o = exp_o(0, 0, 0, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "redirect_prio";  e.i = idle;
        e.i.redir = 1; e.i.hlt = 1; e.i.ex_rd = 5; e.i.ex_we = 1; e.i.ex_m2r = 1;
        e.i.rs1 = 5; e.i.use1 = 1;
        e.o = exp_o(0, 1, 1, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "after_redirect"; e.i = idle;
        e.o = exp_o(0, 0, 0, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "split_ab";       e.i = idle;
        e.i.mem_rd = 4; e.i.mem_we = 1; e.i.wb_rd = 2; e.i.wb_we = 1;
        e.i.rs1 = 2; e.i.rs2 = 4; e.i.use1 = 1; e.i.use2 = 1;
        e.o = FWD ? exp_o(0, 0, 0, 2'b01, 2'b10) : exp_o(1, 0, 1, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "ex_alu_raw";     e.i = idle;
        e.i.ex_rd = 6; e.i.ex_we = 1; e.i.rs2 = 6; e.i.use2 = 1;
        e.o = exp_o(!FWD, 0, !FWD, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "unused_src";     e.i = idle;
        e.i.ex_rd = 5; e.i.ex_we = 1; e.i.ex_m2r = 1; e.i.rs1 = 5;
        e.o = exp_o(0, 0, 0, 2'b00, 2'b00); tbl.push_back(e);
        e.name = "dmem_ready_now"; e.i = idle;
        e.i.req = 1; e.i.ready = 1;
        e.o = exp_o(0, 0, 0, 2'b00, 2'b00); tbl.push_back(e);

        #2;
        chk("reset_outputs", 32'(dut_out()), 32'(out_t'('0)));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            cur = tbl[k].i;
            #1;
            chk(tbl[k].name, 32'(dut_out()), 32'(tbl[k].o));
            model_next(tbl[k].i);
            @(posedge clk);
            #1;
        end

        // Load-use, then the producer moves to MEM and finally to WB
        v = idle; v.ex_rd = 5; v.ex_we = 1; v.ex_m2r = 1; v.rs1 = 5; v.use1 = 1; v.rs2 = 1; v.use2 = 1;
        step(v, "lu_stall");
        v = idle; v.mem_rd = 5; v.mem_we = 1; v.rs1 = 5; v.use1 = 1; v.rs2 = 1; v.use2 = 1;
        cur = v;
        #1;
        chk("lu_next_fwd_a", 32'(fwd_a), FWD ? 32'h2 : 32'h0);
        chk("lu_next_stall", 32'(stall_if), FWD ? 32'h0 : 32'h1);
        model_next(v);
        @(posedge clk);
        #1;
        v = idle; v.wb_rd = 5; v.wb_we = 1; v.rs1 = 5; v.use1 = 1;
        step(v, "lu_producer_in_wb");

        // Three-cycle memory wait, released on the fourth
        nfreeze = 0;
        for (int c = 0; c < 4; c++) begin
            v = idle; v.req = 1; v.ready = (c == 3);
            cur = v;
            #1;
            if (bubble_wb && stall_mem) nfreeze++;
            chk("memwait", 32'(dut_out()), 32'(model_out(v)));
            model_next(v);
            @(posedge clk);
            #1;
        end
        chk("memwait_freeze_count", 32'(nfreeze), 32'd3);
        step(idle, "memwait_after");

        // Plain halt: accept, DRAIN cycles, then halted
        v = idle; v.hlt = 1;
        step(v, "halt_accept");
        for (int c = 0; c < int'(DRAIN); c++) step(v, "halt_drain");
        chk("halted_on_cycle4", 32'(halted), 32'h1);
        step(v, "halted_hold");
        do_reset(idle, "reset_from_halted");
        chk("halted_drops", 32'(halted), 32'h0);

        // Halt with a two-cycle memory wait during drain
        v = idle; v.hlt = 1;
        step(v, "halt2_accept");
        v = idle; v.req = 1;
        step(v, "halt2_freeze1");
        step(v, "halt2_freeze2");
        v.ready = 1;
        step(v, "halt2_release");
        step(idle, "halt2_drain_a");
        step(idle, "halt2_drain_b");
        chk("halted_on_cycle6", 32'(halted), 32'h1);

        // Asynchronous reset while halted: must drop before any clock edge
        cur   = idle;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_halted", 32'(halted), 32'h0);
        chk("async_rst_outputs", 32'(dut_out()), 32'(out_t'('0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of a memory wait
        v = idle; v.req = 1;
        step(v, "mw_enter");
        do_reset(idle, "reset_from_memwait");
        step(idle, "mw_after_reset");

        for (int n = 0; n < 1500; n++) begin
            if ((m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0)) begin
                do_reset(rand_in(), "rand_reset");
            end else begin
                step(rand_in(), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
